btn_debounce: RTL and testbench
===============================

Name: btn_debounce

Overview:
- Input-side counterpart to the board's free-running LED blinker: conditions one raw push-button pin into clean, single-cycle events for user logic.
- Runs on the ~12 MHz SB_HFOSC clock.
- Datapath: 2-flop synchronizer, polarity normalisation, debounce FSM with press/release/long-press detection, and a wrapping press counter for LED or debug display.

Parameters:
- DEBOUNCE_CYCLES, 240000: cycles the synchronized input must be stable before a level change is accepted (20 ms at 12 MHz); must be ≥2.
- LONG_PRESS_CYCLES, 12000000: cycles held after an accepted press before long_pulse fires (1 s); must be ≥2.
- REPEAT_CYCLES, 2400000: auto-repeat period; used only with BTN_AUTOREPEAT_EN.
- ACTIVE_LOW, 1: 1 = pressed reads 0 on pin; 0 = pressed reads 1.

Ports:
- clk  in  1  system clock, SB_HFOSC output.
- rst  in  1  synchronous, active-high reset.
- btn_in  in  1  raw asynchronous button pin.
- btn_level  out  1  debounced state, 1 = pressed.
- press_pulse  out  1  one-cycle strobe on accepted press.
- release_pulse  out  1  one-cycle strobe on accepted release.
- long_pulse  out  1  one-cycle strobe when the hold reaches LONG_PRESS_CYCLES.
- press_count  out  8  count of press_pulse strobes, wraps 255→0.

Behaviour:
- Clock and reset: one clock. Reset is synchronous, active-high, sampled on posedge clk.
- Reset values:
  - Outputs: btn_level=0, all pulses=0, press_count=0.
  - Internal: state=RELEASED, counters=0, long_done=0.
  - Sync flops load the "released" pin level.
- Reset mid-operation: discards any in-progress debounce or hold. A button still held at reset release is re-debounced and yields a fresh press_pulse.
- Synchronizer: sync1<=btn_in, sync2<=sync1. s_pressed = sync2 XOR ACTIVE_LOW.
- All outputs are registered. Pulses are high for exactly one cycle.
- States:
  - RELEASED:
    - s_pressed=1 → PRESS_WAIT, db_cnt=0.
  - PRESS_WAIT:
    - s_pressed=0 → RELEASED. Glitch rejected, no output.
    - Else if db_cnt==DEBOUNCE_CYCLES-1 → PRESSED. press_pulse=1, btn_level=1, press_count+=1, hold_cnt=0, long_done=0.
    - Else db_cnt+=1.
  - PRESSED:
    - s_pressed=0 → RELEASE_WAIT, db_cnt=0. hold_cnt is frozen.
    - Else if !long_done and hold_cnt==LONG_PRESS_CYCLES-1 → long_pulse=1, long_done=1.
    - Else if !long_done → hold_cnt+=1.
  - RELEASE_WAIT:
    - s_pressed=1 → PRESSED. Bounce rejected; hold_cnt and long_done are kept.
    - Else if db_cnt==DEBOUNCE_CYCLES-1 → RELEASED. release_pulse=1, btn_level=0.
    - Else db_cnt+=1.
- Latency:
  - btn_in high first sampled at edge k → PRESS_WAIT at edge k+2 → press_pulse registered at edge k+2+DEBOUNCE_CYCLES.
  - Min accepted width is DEBOUNCE_CYCLES+1 samples; width DEBOUNCE_CYCLES is rejected. Release timing is symmetric.
  - long_pulse registered at edge (press edge)+LONG_PRESS_CYCLES.
- Simultaneous events: press_pulse, release_pulse and long_pulse are mutually exclusive by construction. They never fire in the same cycle.
- Counter widths: db_cnt and hold_cnt are $clog2 of their max parameter. Compares are exact (==), never overflow.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined:
  - After long_pulse, while in PRESSED, rep_cnt counts 0..REPEAT_CYCLES-1.
  - On terminal count, press_pulse=1 and press_count+=1, then rep_cnt=0.
  - rep_cnt clears on entry to PRESSED from PRESS_WAIT.
  - rep_cnt freezes in RELEASE_WAIT.
  - First repeat comes REPEAT_CYCLES after long_pulse.
- Undefined: no repeat logic or register. press_pulse fires only on the PRESS_WAIT→PRESSED transition.

Decomposition:
- Package btn_pkg: state enum (RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT) and default cycle constants derived from CLK_HZ=12000000.
- Sub-module sync_2ff: parameterised reset value, reusable for other pins. FSM and counters stay in btn_debounce.

Test Plan:
- All tests use DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=16, REPEAT_CYCLES=8, ACTIVE_LOW=0.
- Clean press: btn_in 0→1 sampled at edge 10, held → press_pulse high one cycle after edge 16, btn_level=1, press_count=1. Release sampled at edge 40 → release_pulse after edge 46, btn_level=0.
- Glitch reject: btn_in high for exactly 4 samples → no pulse, btn_level stays 0. 5 samples → press_pulse fires once.
- Release bounce: while pressed, btn_in low for 3 samples then high → no release_pulse, btn_level stays 1, no second press_pulse.
- Long press: hold 40 cycles after press_pulse → exactly one long_pulse at press+16. With BTN_AUTOREPEAT_EN, press_pulse at long+8, +16, +24 and press_count increments for each.
- Wrap and reset: 256 clean presses → press_count=0. Assert rst during PRESS_WAIT with btn held → outputs clear next edge, then press_pulse after 2+4 cycles from rst deassert.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and default timing for the push-button front end.
// Defaults assume the 12 MHz SB_HFOSC clock.
package btn_pkg;

  localparam int unsigned CLK_HZ = 12000000;

  // 20 ms debounce, 1 s long press, 200 ms auto-repeat
  localparam int unsigned DEF_DEBOUNCE_CYCLES = CLK_HZ / 50;
  localparam int unsigned DEF_LONG_PRESS_CYCLES = CLK_HZ;
  localparam int unsigned DEF_REPEAT_CYCLES = CLK_HZ / 5;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } btn_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous pin.
// Reset value is a parameter so each pin can reset to its idle level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  // Shift the raw pin through two flops to settle metastability
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/btn_debounce.sv
// Push-button conditioner: sync, debounce, press/release/long events.
// Define BTN_AUTOREPEAT_EN to emit repeated presses while held.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
  parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic [7:0] press_count
);

  localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HW = $clog2(LONG_PRESS_CYCLES);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

  logic sync_pin;
  logic s_pressed;

  sync_2ff #(
    .RST_VAL(ACTIVE_LOW)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d_i(btn_in),
    .q_o(sync_pin)
  );

  assign s_pressed = sync_pin ^ ACTIVE_LOW;

  btn_state_e     state_q, state_d;
  logic [DBW-1:0] db_q, db_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic           ldone_q, ldone_d;
  logic           lvl_q, lvl_d;
  logic           pp_q, pp_d;
  logic           rp_q, rp_d;
  logic           lp_q, lp_d;
  logic [7:0]     cnt_q, cnt_d;

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned RW = $clog2(REPEAT_CYCLES);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rep_q, rep_d;
`endif

  // Register FSM state, counters and all outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RELEASED;
      db_q    <= '0;
      hold_q  <= '0;
      ldone_q <= 1'b0;
      lvl_q   <= 1'b0;
      pp_q    <= 1'b0;
      rp_q    <= 1'b0;
      lp_q    <= 1'b0;
      cnt_q   <= '0;
`ifdef BTN_AUTOREPEAT_EN
      rep_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      db_q    <= db_d;
      hold_q  <= hold_d;
      ldone_q <= ldone_d;
      lvl_q   <= lvl_d;
      pp_q    <= pp_d;
      rp_q    <= rp_d;
      lp_q    <= lp_d;
      cnt_q   <= cnt_d;
`ifdef BTN_AUTOREPEAT_EN
      rep_q   <= rep_d;
`endif
    end
  end

  // Next state: accept a level only after it has been stable long enough
  always_comb begin
    state_d = state_q;
    db_d    = db_q;
    hold_d  = hold_q;
    ldone_d = ldone_q;
    lvl_d   = lvl_q;
    pp_d    = 1'b0;
    rp_d    = 1'b0;
    lp_d    = 1'b0;
    cnt_d   = cnt_q;
`ifdef BTN_AUTOREPEAT_EN
    rep_d   = rep_q;
`endif
    unique case (state_q)
      RELEASED: begin
        if (s_pressed) begin
          state_d = PRESS_WAIT;
          db_d    = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s_pressed) begin
          state_d = RELEASED;
        end else if (db_q == DB_LAST) begin
          state_d = PRESSED;
          pp_d    = 1'b1;
          lvl_d   = 1'b1;
          cnt_d   = cnt_q + 8'd1;
          hold_d  = '0;
          ldone_d = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
          rep_d   = '0;
`endif
        end else begin
          db_d = db_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!s_pressed) begin
          state_d = RELEASE_WAIT;
          db_d    = '0;
        end else if (!ldone_q) begin
          if (hold_q == HOLD_LAST) begin
            lp_d    = 1'b1;
            ldone_d = 1'b1;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
`ifdef BTN_AUTOREPEAT_EN
        else if (rep_q == REP_LAST) begin
          pp_d  = 1'b1;
          cnt_d = cnt_q + 8'd1;
          rep_d = '0;
        end else begin
          rep_d = rep_q + 1'b1;
        end
`endif
      end
      RELEASE_WAIT: begin
        if (s_pressed) begin
          state_d = PRESSED;
        end else if (db_q == DB_LAST) begin
          state_d = RELEASED;
          rp_d    = 1'b1;
          lvl_d   = 1'b0;
        end else begin
          db_d = db_q + 1'b1;
        end
      end
      default: state_d = RELEASED;
    endcase
  end

  assign btn_level     = lvl_q;
  assign press_pulse   = pp_q;
  assign release_pulse = rp_q;
  assign long_pulse    = lp_q;
  assign press_count   = cnt_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Randomized and directed bench for btn_debounce.
// Reference model works on run lengths of the synchronized level.
module tb_btn_debounce;

  localparam int D = 4;
  localparam int L = 16;
  localparam int R = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_in = 1'b0;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic long_pulse;
  logic [7:0] press_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  btn_debounce #(
    .DEBOUNCE_CYCLES(D),
    .LONG_PRESS_CYCLES(L),
    .REPEAT_CYCLES(R),
    .ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_in(btn_in),
    .btn_level(btn_level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .long_pulse(long_pulse),
    .press_count(press_count)
  );

  // reference model state
  logic m_p1 = 0, m_p2 = 0;
  logic m_lvl = 0, m_pp = 0, m_rp = 0, m_lp = 0, m_ld = 0;
  int m_run = 0, m_hold = 0, m_rc = 0;
  logic [7:0] m_cnt = 0;

  wire [11:0] obs = {btn_level, press_pulse, release_pulse,
                     long_pulse, press_count};
  wire [11:0] exp_v = {m_lvl, m_pp, m_rp, m_lp, m_cnt};

  // One clock edge of the behavioural model
  task automatic model(input logic r, input logic pin);
    logic s;
    m_pp = 0; m_rp = 0; m_lp = 0;
    if (r) begin
      m_p1 = 0; m_p2 = 0; m_lvl = 0; m_ld = 0;
      m_run = 0; m_hold = 0; m_rc = 0; m_cnt = 0;
      return;
    end
    s = m_p2;
    m_p2 = m_p1;
    m_p1 = pin;
    if (s != m_lvl) begin
      m_run++;
      if (m_run == D + 1) begin
        m_lvl = s;
        m_run = 0;
        if (s) begin
          m_pp = 1; m_cnt++;
          m_hold = 0; m_ld = 0; m_rc = 0;
        end else begin
          m_rp = 1;
        end
      end
    end else if (m_run != 0) begin
      m_run = 0;
    end else if (m_lvl) begin
      if (!m_ld) begin
        m_hold++;
        if (m_hold == L) begin
          m_lp = 1; m_ld = 1;
        end
      end else begin
`ifdef BTN_AUTOREPEAT_EN
        m_rc++;
        if (m_rc == R) begin
          m_pp = 1; m_cnt++; m_rc = 0;
        end
`endif
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model(rst, btn_in);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; btn_in = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs !== 12'h000) begin
        errors++;
        $display("FAIL reset got=%h exp=000", obs);
      end
    end
    rst = 0;
  endtask

  task automatic test_clean_press();
    int pi = -1, ri = -1, np = 0;
    btn_in = 1;
    for (int i = 0; i < 24; i++) begin
      step();
      if (press_pulse) begin np++; if (pi < 0) pi = i; end
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL clean_press i=%0d got=%h exp=%h", i, obs, exp_v);
      end
    end
    checks++;
    if (pi != 6 || np != 1) begin
      errors++;
      $display("FAIL press_latency got=%0d/%0d exp=6/1", pi, np);
    end
    btn_in = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (release_pulse && ri < 0) ri = i;
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL clean_rel i=%0d got=%h exp=%h", i, obs, exp_v);
      end
    end
    checks++;
    if (ri != 6 || btn_level !== 1'b0) begin
      errors++;
      $display("FAIL rel_latency got=%0d lvl=%b exp=6 lvl=0",
               ri, btn_level);
    end
  endtask

  task automatic test_glitch(input int w, input int exp_np);
    int np = 0;
    btn_in = 1;
    for (int i = 0; i < w + 14; i++) begin
      if (i == w) btn_in = 0;
      step();
      if (press_pulse) np++;
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL glitch w=%0d i=%0d got=%h exp=%h",
                 w, i, obs, exp_v);
      end
    end
    checks++;
    if (np != exp_np) begin
      errors++;
      $display("FAIL glitch_count w=%0d got=%0d exp=%0d", w, np, exp_np);
    end
  endtask

  task automatic test_release_bounce();
    int np = 0, nr = 0;
    btn_in = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL bounce_pre got=%h exp=%h", obs, exp_v);
      end
    end
    for (int i = 0; i < 15; i++) begin
      btn_in = (i >= 3);
      step();
      if (press_pulse) np++;
      if (release_pulse) nr++;
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL bounce i=%0d got=%h exp=%h", i, obs, exp_v);
      end
    end
    checks++;
    if (np != 0 || nr != 0 || btn_level !== 1'b1) begin
      errors++;
      $display("FAIL bounce_events got=%0d/%0d/%b exp=0/0/1",
               np, nr, btn_level);
    end
    btn_in = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL bounce_rel got=%h exp=%h", obs, exp_v);
      end
    end
  endtask

  task automatic test_long_press();
    int li = -1, nl = 0, nrep = 0;
    btn_in = 1;
    for (int i = 0; i < 47; i++) begin
      step();
      if (long_pulse) begin nl++; li = i; end
      if (press_pulse && i > 6) nrep++;
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL long i=%0d got=%h exp=%h", i, obs, exp_v);
      end
    end
    checks++;
    if (nl != 1 || li != 6 + L) begin
      errors++;
      $display("FAIL long_timing got=%0d@%0d exp=1@%0d", nl, li, 6 + L);
    end
    checks++;
`ifdef BTN_AUTOREPEAT_EN
    if (nrep != 3) begin
`else
    if (nrep != 0) begin
`endif
      errors++;
      $display("FAIL repeat_count got=%0d", nrep);
    end
    btn_in = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL long_rel got=%h exp=%h", obs, exp_v);
      end
    end
  endtask

  task automatic test_random();
    int left = 0;
    for (int i = 0; i < 1500; i++) begin
      if (left == 0) begin
        btn_in = ~btn_in;
        left = ($urandom_range(0, 3) == 0) ?
               $urandom_range(8, 30) : $urandom_range(1, 7);
      end
      left--;
      step();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL random i=%0d got=%h exp=%h", i, obs, exp_v);
      end
    end
    btn_in = 0;
    for (int i = 0; i < 40; i++) step();
  endtask

  task automatic test_wrap();
    rst = 1;
    step();
    rst = 0;
    for (int n = 0; n < 256; n++) begin
      for (int i = 0; i < 16; i++) begin
        btn_in = (i < 8);
        step();
        checks++;
        if (obs !== exp_v) begin
          errors++;
          $display("FAIL wrap n=%0d got=%h exp=%h", n, obs, exp_v);
        end
      end
    end
    checks++;
    if (press_count !== 8'd0) begin
      errors++;
      $display("FAIL wrap_count got=%0d exp=0", press_count);
    end
  endtask

  task automatic test_reset_mid();
    int pi = -1;
    btn_in = 1;
    for (int i = 0; i < 4; i++) step();
    rst = 1;
    step();
    checks++;
    if (obs !== 12'h000) begin
      errors++;
      $display("FAIL mid_reset got=%h exp=000", obs);
    end
    rst = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (press_pulse && pi < 0) pi = i;
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL mid_after i=%0d got=%h exp=%h", i, obs, exp_v);
      end
    end
    checks++;
    if (pi != 6) begin
      errors++;
      $display("FAIL mid_latency got=%0d exp=6", pi);
    end
    btn_in = 0;
    for (int i = 0; i < 12; i++) step();
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch(D, 0);
    test_glitch(D + 1, 1);
    test_release_bounce();
    test_long_press();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
